// File: rtl/collatz_pkg.sv
// Shared types and default sizes for the Collatz range sweeper.
package collatz_pkg;

   localparam int COLLATZ_W     = 32;
   localparam int COLLATZ_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      EMIT,
      FIN
   } sweep_state_e;

   typedef struct packed {
      logic [COLLATZ_W-1:0]     n;
      logic [COLLATZ_CNT_W-1:0] steps;
      logic                     err;
   } collatz_rec_t;

endpackage

// File: rtl/collatz_if.sv
// Command and result-stream signals of the Collatz sweeper.
// slave: the sweeper side; master: the front end / consumer side.
interface collatz_if #(
   parameter int W     = collatz_pkg::COLLATZ_W,
   parameter int CNT_W = collatz_pkg::COLLATZ_CNT_W
);
   logic             start;
   logic [W-1:0]     base;
   logic [W-1:0]     count;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [W-1:0]     res_n;
   logic [CNT_W-1:0] res_steps;
   logic             res_err;
   logic [CNT_W-1:0] max_steps;
   logic [W-1:0]     max_n;
   logic             sweep_done;

   modport slave (
      input  start, base, count, res_ready,
      output busy, res_valid, res_n, res_steps, res_err,
             max_steps, max_n, sweep_done
   );

   modport master (
      output start, base, count, res_ready,
      input  busy, res_valid, res_n, res_steps, res_err,
             max_steps, max_n, sweep_done
   );
endinterface

// File: rtl/collatz_engine.sv
// Single Collatz iteration engine: one registered value, load/step enables,
// combinational next value, is_one of the next value, and overflow flag.
// Overflow is only reported when COLLATZ_OVERFLOW_DET_EN is defined;
// otherwise 3v+1 wraps silently to W bits and ovf stays low.
module collatz_engine
   import collatz_pkg::*;
#(
   parameter int W = COLLATZ_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] next_val,
   output logic         is_one,
   output logic         ovf
);

   logic [W-1:0] v_q;
   logic [W-1:0] triple;

`ifdef COLLATZ_OVERFLOW_DET_EN
   // 3v+1 needs at most W+2 bits; the top two bits flag an overflow.
   logic [W+1:0] triple_wide;
   assign triple_wide = {2'b00, v_q} + {1'b0, v_q, 1'b0} + (W+2)'(1);
   assign triple      = triple_wide[W-1:0];
   assign ovf         = v_q[0] && (triple_wide[W+1:W] != 2'b00);
`else
   assign triple = (v_q << 1) + v_q + W'(1);
   assign ovf    = 1'b0;
`endif

   assign next_val = v_q[0] ? triple : (v_q >> 1);
   assign is_one   = (next_val == W'(1));

   // Value register: load wins over step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= '0;
      end else if (load) begin
         v_q <= load_val;
      end else if (step) begin
         v_q <= next_val;
      end
   end

endmodule

// File: rtl/collatz_sweep.sv
// Collatz range sweeper: iterates start values base..base+count-1, streams one
// (n, steps, err) record per value and tracks the range maximum.
// Optional build macro: COLLATZ_OVERFLOW_DET_EN (flag 3v+1 overflow as err).
//
// state | meaning
// IDLE  | waiting for start; max_steps/max_n hold last sweep result
// LOAD  | engine <- n, steps <- 0
// RUN   | one Collatz step per cycle until the value reaches 1
// EMIT  | record presented on res_*, waits for res_ready
// FIN   | one-cycle sweep_done pulse
module collatz_sweep
   import collatz_pkg::*;
#(
   parameter int W     = COLLATZ_W,
   parameter int CNT_W = COLLATZ_CNT_W
) (
   input  logic      clk,
   input  logic      reset_n,
   collatz_if.slave  bus
);

   sweep_state_e     state_q, state_d;
   logic [W-1:0]     n_q;
   logic [W-1:0]     rem_q;
   logic [CNT_W-1:0] steps_q;
   logic             err_q;
   logic [CNT_W-1:0] max_steps_q;
   logic [W-1:0]     max_n_q;
   logic             max_vld_q;

   logic             eng_load;
   logic             eng_step;
   logic [W-1:0]     eng_next;
   logic             eng_is_one;
   logic             eng_ovf;
   logic             hs;

   collatz_engine #(.W(W)) u_engine (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (eng_load),
      .step     (eng_step),
      .load_val (n_q),
      .next_val (eng_next),
      .is_one   (eng_is_one),
      .ovf      (eng_ovf)
   );

   assign hs = (state_q == EMIT) && bus.res_ready;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and engine control.
   always_comb begin
      state_d  = state_q;
      eng_load = 1'b0;
      eng_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = (bus.count == '0) ? FIN : LOAD;
            end
         end
         LOAD: begin
            eng_load = 1'b1;
            state_d  = (n_q == W'(1) || n_q == '0) ? EMIT : RUN;
         end
         RUN: begin
            if (eng_ovf) begin
               state_d = EMIT;
            end else begin
               eng_step = 1'b1;
               if (eng_is_one) begin
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (bus.res_ready) begin
               state_d = (rem_q == W'(1)) ? FIN : LOAD;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sweep datapath: current n, remaining count, step counter, err and max.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_q         <= '0;
         rem_q       <= '0;
         steps_q     <= '0;
         err_q       <= 1'b0;
         max_steps_q <= '0;
         max_n_q     <= '0;
         max_vld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  n_q         <= bus.base;
                  rem_q       <= bus.count;
                  max_steps_q <= '0;
                  max_n_q     <= '0;
                  max_vld_q   <= 1'b0;
               end
            end
            LOAD: begin
               steps_q <= '0;
               err_q   <= (n_q == '0);
            end
            RUN: begin
               if (eng_ovf) begin
                  err_q <= 1'b1;
               end else if (steps_q != '1) begin
                  steps_q <= steps_q + CNT_W'(1);
               end
            end
            EMIT: begin
               if (hs) begin
                  // The first valid record always seeds the max, so a sweep
                  // of only zero-step records still reports its first n.
                  if (!err_q && (!max_vld_q || steps_q > max_steps_q)) begin
                     max_steps_q <= steps_q;
                     max_n_q     <= n_q;
                     max_vld_q   <= 1'b1;
                  end
                  n_q   <= n_q + W'(1);
                  rem_q <= rem_q - W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.res_valid  = (state_q == EMIT);
   assign bus.res_n      = n_q;
   assign bus.res_steps  = steps_q;
   assign bus.res_err    = err_q;
   assign bus.max_steps  = max_steps_q;
   assign bus.max_n      = max_n_q;
   assign bus.sweep_done = (state_q == FIN);

endmodule
